// File: rtl/dmr_join_retry_ctrl.sv
// Retry sequencer beside a redundant stream join: asserts repeat while replicas
// resynchronise, counts consecutive failed attempts and latches a sticky fault.
module dmr_join_retry_ctrl #(
    parameter  int unsigned MAX_RETRIES = 3,
    parameter  int unsigned HOLD_CYCLES = 2,
    parameter  int unsigned CNT_W       = 8,
    localparam int unsigned RW          = $clog2(MAX_RETRIES + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic             clear_i,
    input  logic             error_i,
    input  logic             out_valid_i,
    input  logic             out_ready_i,
    output logic             repeat_o,
    output logic             fault_o,
    output logic [RW-1:0]    retry_cnt_o,
    output logic [CNT_W-1:0] err_total_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       hold_q, hold_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [CNT_W-1:0] total_q, total_d;

    logic          success;
    logic          err_ev;
    logic          to_fault;
    logic [RW-1:0] retry_base;

    always_comb begin
        success    = out_valid_i & out_ready_i & ~error_i;
        err_ev     = error_i & enable_i & (state_q == ST_IDLE);
        // A clear in the same cycle as an error restarts the count before the error is added.
        retry_base = (clear_i | success) ? '0 : retry_q;
        to_fault   = err_ev & (retry_base == RW'(MAX_RETRIES));

        state_d = state_q;
        hold_d  = hold_q;
        retry_d = retry_base;
        total_d = total_q;

        case (state_q)
            ST_IDLE: begin
                if (to_fault) begin
                    state_d = ST_FAULT;
                end else if (err_ev) begin
                    state_d = ST_HOLD;
                    hold_d  = 8'(HOLD_CYCLES - 1);
                    retry_d = retry_base + RW'(1);
                end
            end
            ST_HOLD: begin
                if (hold_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            ST_FAULT: begin
                if (clear_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (err_ev && (total_q != '1)) begin
            total_d = total_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            retry_q <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            retry_q <= retry_d;
            total_q <= total_d;
        end
    end

    assign repeat_o    = (state_q != ST_IDLE);
    assign fault_o     = (state_q == ST_FAULT);
    assign retry_cnt_o = retry_q;
    assign err_total_o = total_q;

endmodule

// File: tb/tb_dmr_join_retry_ctrl.sv
// Bench for dmr_join_retry_ctrl: two parameterisations driven in lockstep and
// compared every cycle against a cycle-level behavioural model.
module tb_dmr_join_retry_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, en, clr, err, vld, rdy;

    logic       rep_a, flt_a;
    logic [1:0] cnt_a;
    logic [7:0] tot_a;
    logic       rep_b, flt_b;
    logic [1:0] cnt_b;
    logic [1:0] tot_b;

    dmr_join_retry_ctrl #(.MAX_RETRIES(3), .HOLD_CYCLES(2), .CNT_W(8)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .clear_i(clr), .error_i(err),
        .out_valid_i(vld), .out_ready_i(rdy), .repeat_o(rep_a), .fault_o(flt_a),
        .retry_cnt_o(cnt_a), .err_total_o(tot_a)
    );

    dmr_join_retry_ctrl #(.MAX_RETRIES(2), .HOLD_CYCLES(1), .CNT_W(2)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .clear_i(clr), .error_i(err),
        .out_valid_i(vld), .out_ready_i(rdy), .repeat_o(rep_b), .fault_o(flt_b),
        .retry_cnt_o(cnt_b), .err_total_o(tot_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // model: busy = repeat cycles still owed to the current retry window
    int m_max[2]  = '{3, 2};
    int m_hold[2] = '{2, 1};
    int m_sat[2]  = '{255, 3};
    int m_busy[2] = '{0, 0};
    int m_cnt[2]  = '{0, 0};
    int m_tot[2]  = '{0, 0};
    bit m_flt[2]  = '{1'b0, 1'b0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            bit idle, succ, ev;
            int base;
            idle = (m_busy[k] == 0) && !m_flt[k];
            succ = vld && rdy && !err;
            ev   = err && en && idle;
            base = (clr || succ) ? 0 : m_cnt[k];
            if (!rst_n) begin
                m_busy[k] = 0; m_cnt[k] = 0; m_tot[k] = 0; m_flt[k] = 1'b0;
            end else begin
                if (m_flt[k]) begin
                    if (clr) m_flt[k] = 1'b0;
                end else if (m_busy[k] > 0) begin
                    m_busy[k]--;
                end else if (ev && base == m_max[k]) begin
                    m_flt[k] = 1'b1;
                end else if (ev) begin
                    m_busy[k] = m_hold[k];
                end
                m_cnt[k] = base + ((ev && base != m_max[k]) ? 1 : 0);
                if (ev && m_tot[k] < m_sat[k]) m_tot[k]++;
            end
        end
    endtask

    task automatic check_all();
        chk("a_repeat", 32'(rep_a), 32'(m_flt[0] || m_busy[0] > 0));
        chk("a_fault",  32'(flt_a), 32'(m_flt[0]));
        chk("a_retry",  32'(cnt_a), 32'(m_cnt[0]));
        chk("a_total",  32'(tot_a), 32'(m_tot[0]));
        chk("b_repeat", 32'(rep_b), 32'(m_flt[1] || m_busy[1] > 0));
        chk("b_fault",  32'(flt_b), 32'(m_flt[1]));
        chk("b_retry",  32'(cnt_b), 32'(m_cnt[1]));
        chk("b_total",  32'(tot_b), 32'(m_tot[1]));
    endtask

    task automatic step(input logic r, input logic e, input logic c, input logic er,
                        input logic v, input logic rd);
        rst_n = r; en = e; clr = c; err = er; vld = v; rdy = rd;
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic idle_step();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic err_step();
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic hs_step();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic rst_step();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; err = 1'b0; vld = 1'b0; rdy = 1'b0;

        // reset, single error at cycle 10, retry window timing
        rst_step(); rst_step();
        chk("rst_repeat", 32'(rep_a), 32'd0);
        chk("rst_total",  32'(tot_a), 32'd0);
        for (int i = 0; i < 7; i++) idle_step();
        err_step();
        chk("tp1_rep_n1", 32'(rep_a), 32'd1);
        idle_step();
        chk("tp1_rep_n2", 32'(rep_a), 32'd1);
        idle_step();
        chk("tp1_rep_n3", 32'(rep_a), 32'd0);
        chk("tp1_retry",  32'(cnt_a), 32'd1);
        chk("tp1_total",  32'(tot_a), 32'd1);
        hs_step();
        chk("tp2_retry",  32'(cnt_a), 32'd0);
        chk("tp2_total",  32'(tot_a), 32'd1);

        // continuous error exhausts the budget, then clear
        rst_step();
        for (int i = 0; i < 12; i++) err_step();
        chk("tp3_fault",  32'(flt_a), 32'd1);
        chk("tp3_repeat", 32'(rep_a), 32'd1);
        chk("tp3_total",  32'(tot_a), 32'd4);
        chk("tp3_retry",  32'(cnt_a), 32'd3);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("tp3_clr_fault",  32'(flt_a), 32'd0);
        chk("tp3_clr_repeat", 32'(rep_a), 32'd0);
        chk("tp3_clr_retry",  32'(cnt_a), 32'd0);
        chk("tp3_clr_total",  32'(tot_a), 32'd4);

        // disabled errors ignored, error during hold ignored, handshake with enable low
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("tp4_dis_repeat", 32'(rep_a), 32'd0);
        err_step(); err_step(); err_step();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("tp4_hold_repeat", 32'(rep_a), 32'd0);
        chk("tp4_hold_retry",  32'(cnt_a), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("tp4_dis_hs_retry", 32'(cnt_a), 32'd0);

        // spaced errors saturate the narrow counter without faulting
        for (int i = 0; i < 7; i++) begin
            err_step(); idle_step(); idle_step(); hs_step();
        end
        chk("tp5_b_total", 32'(tot_b), 32'd3);
        chk("tp5_b_fault", 32'(flt_b), 32'd0);

        // reset mid-hold and mid-fault
        err_step(); idle_step();
        rst_step();
        chk("tp6_hold_rep",   32'(rep_a), 32'd0);
        chk("tp6_hold_total", 32'(tot_a), 32'd0);
        for (int i = 0; i < 10; i++) err_step();
        chk("tp6_in_fault", 32'(flt_a), 32'd1);
        rst_step();
        chk("tp6_flt_fault", 32'(flt_a), 32'd0);
        chk("tp6_flt_rep",   32'(rep_a), 32'd0);
        chk("tp6_flt_retry", 32'(cnt_a), 32'd0);
        err_step();
        chk("tp6_restart_retry", 32'(cnt_a), 32'd1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int perr;
            perr = (i / 500) % 3;
            step(($urandom_range(199) != 0),
                 ($urandom_range(7) != 0),
                 ($urandom_range(39) == 0),
                 ($urandom_range(9) < perr * 3 + 1),
                 ($urandom_range(1) == 1),
                 ($urandom_range(3) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
